icache: RTL and testbench

Direct-mapped instruction cache that sits between the core's fetch stage and the instruction memory (`im`). It serves hits from its own line storage in one cycle. On a miss it issues a single read to `im`, captures the 16-word burst `im` returns, and writes it as one 64-byte line. It then answers the fetch and keeps saturating hit/miss counters for performance measurement.

---
 rtl/icache.sv | 192 +++++++++++++++++++
 tb/tb_icache.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// icache -- direct-mapped instruction cache between the fetch stage and the
// instruction memory (im). Hits are answered one cycle after the request is
// sampled. A miss issues one read strobe to im, captures the 16-word burst
// into a 64-byte line, then answers the fetch from that line.
//
// Ports:
//   clock, reset       clock and asynchronous active-low reset
//   IC_enable          fetch request, sampled only while IC_busy is low
//   IC_address         fetch byte address (bits [1:0] ignored)
//   IC_flush           one-cycle pulse that invalidates every line
//   IC_out, IC_ready   fetched word and its one-cycle valid pulse
//   IC_busy            a miss is being serviced; requests are ignored
//   IM_enable, IM_read one-cycle read strobe towards im
//   IM_write, IM_in    unused write path, tied to zero
//   IM_address         line base address of the miss
//   IM_out, IM_ready   burst data and its per-word valid from im
//   hit_count          saturating hit counter
//   miss_count         saturating miss counter

module icache #(
    parameter int data_size  = 32,
    parameter int addr_size  = 12,
    parameter int index_bits = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 IC_enable,
    input  logic [addr_size-1:0] IC_address,
    input  logic                 IC_flush,
    output logic [data_size-1:0] IC_out,
    output logic                 IC_ready,
    output logic                 IC_busy,
    output logic                 IM_enable,
    output logic                 IM_read,
    output logic                 IM_write,
    output logic [addr_size-1:0] IM_address,
    output logic [data_size-1:0] IM_in,
    input  logic [data_size-1:0] IM_out,
    input  logic                 IM_ready,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
);

    localparam int TAG_W = addr_size - 6 - index_bits;
    localparam int LINES = 1 << index_bits;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_FILL, S_RESP} state_t;

    state_t state;
    state_t next_state;

    logic [data_size-1:0]  data_mem [0:LINES*16-1];
    logic [TAG_W-1:0]      tag_mem  [0:LINES-1];
    logic [LINES-1:0]      valid;
    logic                  flush_pending;
    logic [3:0]            fill_cnt;

    logic [index_bits-1:0] req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [3:0]            req_off;

    logic [3:0]            fetch_off;
    logic [index_bits-1:0] fetch_idx;
    logic [TAG_W-1:0]      fetch_tag;
    logic                  hit;
    logic                  mem_we;
    logic [3:0]            wr_off;
    logic                  line_done;
    logic                  unused_bits;

    assign fetch_off   = IC_address[5:2];
    assign fetch_idx   = IC_address[5+index_bits:6];
    assign fetch_tag   = IC_address[addr_size-1:6+index_bits];
    assign unused_bits = ^IC_address[1:0];

    assign IM_write = 1'b0;
    assign IM_in    = '0;

    // A flush arriving together with a request wipes the line the request
    // would hit, so it is forced down the miss path.
    assign hit = IC_enable && !IC_flush && valid[fetch_idx] &&
                 (tag_mem[fetch_idx] == fetch_tag);

    // Burst words land at offset 0 in WAIT and at the running counter in FILL.
    assign mem_we    = IM_ready && ((state == S_WAIT) || (state == S_FILL));
    assign wr_off    = (state == S_WAIT) ? 4'd0 : fill_cnt;
    assign line_done = IM_ready && (state == S_FILL) && (fill_cnt == 4'd15);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (IC_enable && !hit) next_state = S_REQ;
            S_REQ:   next_state = S_WAIT;
            S_WAIT:  if (IM_ready) next_state = S_FILL;
            S_FILL:  if (line_done) next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Line storage has no reset; a line only becomes usable through its valid
    // bit, which is set once the last burst word has been written.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            data_mem[{req_idx, wr_off}] <= IM_out;
        end
        if (line_done) begin
            tag_mem[req_idx] <= req_tag;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            IC_out        <= '0;
            IC_ready      <= 1'b0;
            IC_busy       <= 1'b0;
            IM_enable     <= 1'b0;
            IM_read       <= 1'b0;
            IM_address    <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
            valid         <= '0;
            flush_pending <= 1'b0;
            fill_cnt      <= '0;
            req_idx       <= '0;
            req_tag       <= '0;
            req_off       <= '0;
        end else begin
            IC_ready  <= 1'b0;
            IM_enable <= 1'b0;
            IM_read   <= 1'b0;

            // Flushes seen while a miss is in flight are deferred so the
            // line being filled still answers its own request.
            if (IC_flush && (state != S_IDLE)) begin
                flush_pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (IC_flush) begin
                        valid <= '0;
                    end
                    if (IC_enable) begin
                        if (hit) begin
                            IC_out   <= data_mem[{fetch_idx, fetch_off}];
                            IC_ready <= 1'b1;
                            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                        end else begin
                            req_idx    <= fetch_idx;
                            req_tag    <= fetch_tag;
                            req_off    <= fetch_off;
                            IM_enable  <= 1'b1;
                            IM_read    <= 1'b1;
                            IM_address <= {IC_address[addr_size-1:6], 6'b000000};
                            IC_busy    <= 1'b1;
                            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (IM_ready) fill_cnt <= 4'd1;
                end
                S_FILL: begin
                    if (IM_ready) begin
                        fill_cnt <= fill_cnt + 4'd1;
                        if (fill_cnt == 4'd15) valid[req_idx] <= 1'b1;
                    end
                end
                S_RESP: begin
                    IC_out   <= data_mem[{req_idx, req_off}];
                    IC_ready <= 1'b1;
                    IC_busy  <= 1'b0;
                    if (flush_pending || IC_flush) begin
                        valid         <= '0;
                        flush_pending <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb_icache -- self-checking bench for icache. A behavioural instruction
// memory answers every read strobe with a 16-word burst (word value derived
// from the byte address), with selectable ready-gap patterns. Fixed vectors
// cover the directed cases; random fetches are checked against a small
// line-level cache model.
`timescale 1ns/1ns

module tb_icache;

    logic        clock;
    logic        reset;
    logic        IC_enable;
    logic [11:0] IC_address;
    logic        IC_flush;
    logic [31:0] IC_out;
    logic        IC_ready;
    logic        IC_busy;
    logic        IM_enable;
    logic        IM_read;
    logic        IM_write;
    logic [11:0] IM_address;
    logic [31:0] IM_in;
    logic [31:0] IM_out;
    logic        IM_ready;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int n_vec = 0;
    int n_err = 0;

    int          en_cycles = 0;
    int          gap_mode  = 0;
    int          burst_idx = 0;
    logic        mem_busy  = 1'b0;
    logic [11:0] last_base = '0;
    logic        last_read = 1'b0;

    logic m_valid [4];
    int   m_tag   [4];
    int   m_hits;
    int   m_misses;

    typedef struct {
        logic [11:0] addr;
        logic        flush;
        int          gap;
        logic        exp_hit;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [11];

    icache dut (
        .clock      (clock),
        .reset      (reset),
        .IC_enable  (IC_enable),
        .IC_address (IC_address),
        .IC_flush   (IC_flush),
        .IC_out     (IC_out),
        .IC_ready   (IC_ready),
        .IC_busy    (IC_busy),
        .IM_enable  (IM_enable),
        .IM_read    (IM_read),
        .IM_write   (IM_write),
        .IM_address (IM_address),
        .IM_in      (IM_in),
        .IM_out     (IM_out),
        .IM_ready   (IM_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Memory content: every word holds 0x0FF0 plus its word address.
    function automatic logic [31:0] mem_word(input int a);
        return 32'h0000_0FF0 + (a / 4);
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
        end
        m_hits   = 0;
        m_misses = 0;
    endfunction

    // Line-level view: 4 lines of 64 bytes, tag is everything above 256 bytes.
    function automatic void modelFetch(input int a, input logic fl,
                                       output logic exp_hit, output logic [31:0] exp_data);
        int idx;
        int tag;
        idx = (a / 64) % 4;
        tag = a / 256;
        if (fl) begin
            for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        end
        exp_hit = !fl && m_valid[idx] && (m_tag[idx] == tag);
        if (exp_hit) begin
            if (m_hits < 65535) m_hits++;
        end else begin
            if (m_misses < 65535) m_misses++;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
        end
        exp_data = mem_word(a);
    endfunction

    // Count every cycle the read strobe is high, sampled mid-cycle.
    always @(negedge clock) begin
        if (IM_enable === 1'b1) en_cycles++;
    end

    // Behavioural instruction memory: waits for a strobe, then streams the
    // 16 words of the requested line using the current gap pattern.
    initial begin : mem_server
        int          lat;
        int          p;
        logic [11:0] base;
        logic        rdy;
        IM_ready = 1'b0;
        IM_out   = '0;
        forever begin
            @(posedge clock); #1;
            if (IM_enable === 1'b1) begin
                base      = IM_address;
                last_base = IM_address;
                last_read = IM_read;
                mem_busy  = 1'b1;
                burst_idx = 0;
                lat = (gap_mode == 2) ? int'($urandom_range(1, 4)) : 1;
                repeat (lat) begin
                    @(posedge clock); #1;
                end
                p = 0;
                while (burst_idx < 16) begin
                    if (gap_mode == 0)      rdy = 1'b1;
                    else if (gap_mode == 1) rdy = ((p % 5) != 1) && ((p % 5) != 4);
                    else                    rdy = ($urandom_range(0, 2) != 0);
                    if (rdy) begin
                        IM_ready = 1'b1;
                        IM_out   = mem_word(int'(base) + 4 * burst_idx);
                        burst_idx++;
                    end else begin
                        IM_ready = 1'b0;
                        IM_out   = 32'hDEAD_BEEF;
                    end
                    p++;
                    @(posedge clock); #1;
                end
                IM_ready = 1'b0;
                IM_out   = '0;
                mem_busy = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic boundFail(input string name);
        n_vec++;
        n_err++;
        $display("[TB] FAIL %s: wait bound expired, got no event, expected event", name);
    endtask

    // Issue one fetch (entered and left at posedge+1) and wait for IC_ready.
    task automatic applyStimulus(input logic [11:0] addr, input logic flush,
                                 output logic [31:0] data, output int strobes,
                                 output logic busy_seen, output logic ready_after,
                                 output logic timed_out);
        int en0;
        int n;
        en0        = en_cycles;
        timed_out  = 1'b0;
        data       = '0;
        IC_address = addr;
        IC_flush   = flush;
        IC_enable  = 1'b1;
        @(posedge clock); #1;
        IC_enable = 1'b0;
        IC_flush  = 1'b0;
        busy_seen = IC_busy;
        n = 0;
        while (!IC_ready && n < 300) begin
            @(posedge clock); #1;
            n++;
        end
        if (!IC_ready) timed_out = 1'b1;
        else           data = IC_out;
        strobes = en_cycles - en0;
        @(posedge clock); #1;
        ready_after = IC_ready;
    endtask

    task automatic runFetch(input logic [11:0] addr, input logic flush,
                            input logic exp_hit, input logic [31:0] exp_data);
        logic [31:0] data;
        int          strobes;
        logic        busy_seen;
        logic        ready_after;
        logic        timed_out;
        applyStimulus(addr, flush, data, strobes, busy_seen, ready_after, timed_out);
        if (timed_out) begin
            boundFail("fetch_ready");
        end else begin
            checkOutput("ic_out", data, exp_data);
            checkOutput("im_strobe_cycles", strobes, exp_hit ? 32'd0 : 32'd1);
            checkOutput("ready_single_pulse", {31'd0, ready_after}, 32'd0);
            if (!exp_hit) begin
                checkOutput("busy_during_miss", {31'd0, busy_seen}, 32'd1);
                checkOutput("im_address", {20'd0, last_base}, {20'd0, addr & 12'hFC0});
                checkOutput("im_read", {31'd0, last_read}, 32'd1);
            end
        end
    endtask

    task automatic waitReady(output logic [31:0] data, output logic ok);
        int n;
        n = 0;
        while (!IC_ready && n < 300) begin
            @(posedge clock); #1;
            n++;
        end
        ok   = IC_ready;
        data = IC_out;
    endtask

    initial begin : main
        logic        h;
        logic [31:0] d;
        logic        ok;
        logic        spurious;
        int          n;
        int          e0;
        int          a;
        logic        fl;

        // 0x140 shares line index 1 with 0x040 under a different tag.
        vecs[0]  = '{12'h040, 1'b0, 0, 1'b0, 32'h1000};
        vecs[1]  = '{12'h044, 1'b0, 0, 1'b1, 32'h1001};
        vecs[2]  = '{12'h07C, 1'b0, 0, 1'b1, 32'h100F};
        vecs[3]  = '{12'h140, 1'b0, 0, 1'b0, 32'h1040};
        vecs[4]  = '{12'h040, 1'b0, 1, 1'b0, 32'h1000};
        vecs[5]  = '{12'h064, 1'b0, 0, 1'b1, 32'h1009};
        vecs[6]  = '{12'h080, 1'b1, 0, 1'b0, 32'h1010};
        vecs[7]  = '{12'h040, 1'b0, 0, 1'b0, 32'h1000};
        vecs[8]  = '{12'h0C8, 1'b0, 2, 1'b0, 32'h1022};
        vecs[9]  = '{12'h0CB, 1'b0, 0, 1'b1, 32'h1022};
        vecs[10] = '{12'h080, 1'b0, 0, 1'b1, 32'h1010};

        IC_enable  = 1'b0;
        IC_flush   = 1'b0;
        IC_address = '0;
        reset      = 1'b1;
        #1 reset = 1'b0;
        #2;
        checkOutput("rst_ic_out", IC_out, 32'd0);
        checkOutput("rst_flags", {27'd0, IC_ready, IC_busy, IM_enable, IM_read, IM_write}, 32'd0);
        checkOutput("rst_im_address", {20'd0, IM_address}, 32'd0);
        checkOutput("rst_counts", {hit_count, miss_count}, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;

        $display("[TB] directed vectors");
        for (int i = 0; i < 11; i++) begin
            gap_mode = vecs[i].gap;
            runFetch(vecs[i].addr, vecs[i].flush, vecs[i].exp_hit, vecs[i].exp_data);
        end
        checkOutput("hit_count_table", {16'd0, hit_count}, 32'd5);
        checkOutput("miss_count_table", {16'd0, miss_count}, 32'd6);

        $display("[TB] back-to-back hits");
        e0 = en_cycles;
        IC_address = 12'h044;
        IC_enable  = 1'b1;
        @(posedge clock); #1;
        checkOutput("b2b_ready_first", {31'd0, IC_ready}, 32'd1);
        checkOutput("b2b_out_first", IC_out, 32'h1001);
        IC_address = 12'h07C;
        @(posedge clock); #1;
        checkOutput("b2b_ready_second", {31'd0, IC_ready}, 32'd1);
        checkOutput("b2b_out_second", IC_out, 32'h100F);
        IC_enable = 1'b0;
        @(posedge clock); #1;
        checkOutput("b2b_ready_drop", {31'd0, IC_ready}, 32'd0);
        checkOutput("b2b_strobes", en_cycles - e0, 32'd0);
        checkOutput("b2b_hit_count", {16'd0, hit_count}, 32'd7);

        $display("[TB] flush during fill");
        gap_mode   = 0;
        IC_address = 12'h200;
        IC_enable  = 1'b1;
        @(posedge clock); #1;
        IC_enable = 1'b0;
        #1;
        n = 0;
        while (burst_idx < 3 && n < 100) begin
            @(posedge clock); #2;
            n++;
        end
        if (burst_idx < 3) boundFail("flush_fill_reach");
        IC_flush = 1'b1;
        @(posedge clock); #1;
        IC_flush = 1'b0;
        waitReady(d, ok);
        if (!ok) boundFail("flush_fill_ready");
        else     checkOutput("flush_fill_out", d, 32'h1070);
        @(posedge clock); #1;
        runFetch(12'h200, 1'b0, 1'b0, 32'h1070);
        checkOutput("flush_miss_count", {16'd0, miss_count}, 32'd8);

        $display("[TB] reset during fill");
        gap_mode   = 0;
        IC_address = 12'h2C0;
        IC_enable  = 1'b1;
        @(posedge clock); #1;
        IC_enable = 1'b0;
        #1;
        n = 0;
        while (burst_idx < 6 && n < 100) begin
            @(posedge clock); #2;
            n++;
        end
        if (burst_idx < 6) boundFail("reset_fill_reach");
        #2 reset = 1'b0;
        #1;
        checkOutput("midrst_flags", {28'd0, IC_ready, IC_busy, IM_enable, IM_read}, 32'd0);
        checkOutput("midrst_ic_out", IC_out, 32'd0);
        checkOutput("midrst_im_address", {20'd0, IM_address}, 32'd0);
        checkOutput("midrst_counts", {hit_count, miss_count}, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        spurious = 1'b0;
        n = 0;
        while (mem_busy && n < 100) begin
            @(posedge clock); #1;
            if (IC_ready || IC_busy) spurious = 1'b1;
            n++;
        end
        if (mem_busy) boundFail("reset_fill_drain");
        @(posedge clock); #1;
        checkOutput("tail_burst_ignored", {31'd0, spurious}, 32'd0);
        modelReset();
        modelFetch(12'h2C0, 1'b0, h, d);
        runFetch(12'h2C0, 1'b0, h, d);

        $display("[TB] random fetches");
        for (int i = 0; i < 200; i++) begin
            a        = int'($urandom_range(0, 1023));
            fl       = ($urandom_range(0, 9) == 0);
            gap_mode = int'($urandom_range(0, 2));
            modelFetch(a, fl, h, d);
            runFetch(a[11:0], fl, h, d);
        end
        checkOutput("rand_hit_count", {16'd0, hit_count}, m_hits);
        checkOutput("rand_miss_count", {16'd0, miss_count}, m_misses);

        $display("[TB] hit counter saturation");
        gap_mode = 0;
        modelFetch(12'h2C0, 1'b0, h, d);
        runFetch(12'h2C0, 1'b0, h, d);
        IC_address = 12'h2C0;
        IC_enable  = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clock); #1;
            modelFetch(12'h2C0, 1'b0, h, d);
        end
        checkOutput("sat_last_out", IC_out, d);
        IC_enable = 1'b0;
        @(posedge clock); #1;
        checkOutput("sat_hit_model", {16'd0, hit_count}, m_hits);
        checkOutput("sat_hit_max", {16'd0, hit_count}, 32'h0000FFFF);
        checkOutput("sat_miss_count", {16'd0, miss_count}, m_misses);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
